// File: rtl/pgm_cen_gen.sv
// Fractional clock-enable generator: each channel emits cen at clk*num/den
// using a remainder accumulator, plus alternating cen_p/cen_n half-rate phases.
module pgm_cen_gen #(
  parameter int CHANNELS = 2,
  parameter int ACC_W    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*ACC_W-1:0] num,
  input  logic [CHANNELS*ACC_W-1:0] den,
  input  logic                      cfg_load,
  input  logic [CHANNELS-1:0]       pause,
  output logic [CHANNELS-1:0]       cen,
  output logic [CHANNELS-1:0]       cen_p,
  output logic [CHANNELS-1:0]       cen_n,
  output logic [CHANNELS-1:0]       cfg_err
);

  logic [ACC_W-1:0] num_r [CHANNELS];
  logic [ACC_W-1:0] den_r [CHANNELS];
  logic [ACC_W:0]   acc   [CHANNELS];
  logic [ACC_W:0]   sum   [CHANNELS];
  logic [CHANNELS-1:0] ph;
  logic [CHANNELS-1:0] hit;

  // acc stays below den_r, so one conditional subtract keeps it in range;
  // a zero numerator must never fire even though 0 >= den_r when den_r is 0.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      sum[i] = acc[i] + {1'b0, num_r[i]};
      hit[i] = (num_r[i] != '0) && (sum[i] >= {1'b0, den_r[i]});
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        num_r[i] <= '0;
        den_r[i] <= '0;
        acc[i]   <= '0;
      end
      ph      <= '0;
      cen     <= '0;
      cen_p   <= '0;
      cen_n   <= '0;
      cfg_err <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (cfg_load) begin
          num_r[i]   <= num[i*ACC_W +: ACC_W];
          den_r[i]   <= den[i*ACC_W +: ACC_W];
          acc[i]     <= '0;
          ph[i]      <= 1'b0;
          cen[i]     <= 1'b0;
          cen_p[i]   <= 1'b0;
          cen_n[i]   <= 1'b0;
          cfg_err[i] <= (den[i*ACC_W +: ACC_W] == '0) ||
                        (num[i*ACC_W +: ACC_W] > den[i*ACC_W +: ACC_W]);
        end else if (pause[i] || cfg_err[i]) begin
          cen[i]   <= 1'b0;
          cen_p[i] <= 1'b0;
          cen_n[i] <= 1'b0;
        end else if (hit[i]) begin
          acc[i]   <= sum[i] - {1'b0, den_r[i]};
          cen[i]   <= 1'b1;
          cen_p[i] <= ~ph[i];
          cen_n[i] <= ph[i];
          ph[i]    <= ~ph[i];
        end else begin
          acc[i]   <= sum[i];
          cen[i]   <= 1'b0;
          cen_p[i] <= 1'b0;
          cen_n[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pgm_cen_gen.sv
// Self-checking bench for pgm_cen_gen: per-cycle scoreboard against a
// floor(k*num/den) reference model, plus ratio table and corner sequences.
module tb_pgm_cen_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] num;
  logic [31:0] den;
  logic        cfg_load;
  logic [1:0]  pause;
  logic [1:0]  cen;
  logic [1:0]  cen_p;
  logic [1:0]  cen_n;
  logic [1:0]  cfg_err;

  pgm_cen_gen #(.CHANNELS(2), .ACC_W(16)) dut (
    .clk(clk), .reset(reset), .num(num), .den(den), .cfg_load(cfg_load),
    .pause(pause), .cen(cen), .cen_p(cen_p), .cen_n(cen_n), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  longint m_k [2];
  longint m_n [2];
  longint m_d [2];
  bit     m_err [2];
  int     m_cnt [2];
  logic [7:0] exp_q [$];

  // pulse counters observed on the DUT
  int pc [2];
  int pp [2];
  int pn [2];

  typedef struct {
    int n0; int d0; int n1; int d1;
    int cyc; int p0; int p1;
    logic [1:0] err;
  } vec_t;
  vec_t tbl [7];

  // Expected outputs come from the closed form: pulse after active edge k
  // iff floor(k*n/d) > floor((k-1)*n/d); the pulse index parity picks p/n.
  task automatic modelStep();
    logic [1:0] c, p, q, e;
    c = '0; p = '0; q = '0;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_n[i] = 0; m_d[i] = 0; m_k[i] = 0; m_cnt[i] = 0; m_err[i] = 0;
      end else if (cfg_load) begin
        m_n[i] = longint'(num[i*16 +: 16]);
        m_d[i] = longint'(den[i*16 +: 16]);
        m_k[i] = 0; m_cnt[i] = 0;
        m_err[i] = (m_d[i] == 0) || (m_n[i] > m_d[i]);
      end else if (!pause[i] && !m_err[i]) begin
        m_k[i]++;
        if (m_n[i] != 0 && ((m_k[i] * m_n[i]) / m_d[i]) > (((m_k[i] - 1) * m_n[i]) / m_d[i])) begin
          m_cnt[i]++;
          c[i] = 1'b1;
          p[i] = (m_cnt[i] % 2) == 1;
          q[i] = (m_cnt[i] % 2) == 0;
        end
      end
      e[i] = m_err[i];
    end
    exp_q.push_back({e, q, p, c});
  endtask

  task automatic checkOutput();
    logic [7:0] exp_v;
    logic [7:0] act_v;
    act_v = {cfg_err, cen_n, cen_p, cen};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty actual=%b required=entry", act_v);
    end else begin
      exp_v = exp_q.pop_front();
      if (act_v !== exp_v) begin
        errors++;
        $display("[TB] FAIL cycle_outputs t=%0t actual=%b required=%b", $time, act_v, exp_v);
      end
    end
    for (int i = 0; i < 2; i++) begin
      pc[i] += int'(cen[i]);
      pp[i] += int'(cen_p[i]);
      pn[i] += int'(cen_n[i]);
    end
  endtask

  task automatic cycle();
    modelStep();
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic clearCounts();
    for (int i = 0; i < 2; i++) begin
      pc[i] = 0; pp[i] = 0; pn[i] = 0;
    end
  endtask

  task automatic checkVal(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic applyStimulus(input int n0, input int d0, input int n1, input int d1);
    num = {n1[15:0], n0[15:0]};
    den = {d1[15:0], d0[15:0]};
    cfg_load = 1'b1;
    cycle();
    cfg_load = 1'b0;
    clearCounts();
  endtask

  initial begin
    int first_pos [4];
    int found;
    int wait_cyc;

    reset = 1'b1; cfg_load = 1'b0; pause = 2'b00; num = '0; den = '0;
    clearCounts();
    @(negedge clk);
    cycle();
    cycle();
    checkVal("reset_outputs", int'({cfg_err, cen_n, cen_p, cen}), 0);
    reset = 1'b0;

    // no config loaded: num_r = 0 must stay silent
    for (int c = 0; c < 10; c++) cycle();
    checkVal("idle_no_pulse", pc[0] + pc[1], 0);

    tbl[0] = '{2, 5, 4, 25, 50, 20, 8, 2'b00};
    tbl[1] = '{2, 5, 4, 25, 2500, 1000, 400, 2'b00};
    tbl[2] = '{3, 7, 1, 3, 70, 30, 23, 2'b00};
    tbl[3] = '{0, 5, 5, 8, 100, 0, 62, 2'b00};
    tbl[4] = '{1, 0, 7, 3, 40, 0, 0, 2'b11};
    tbl[5] = '{1, 1, 1, 1, 10, 10, 10, 2'b00};
    tbl[6] = '{65535, 65535, 1, 65535, 20, 20, 0, 2'b00};

    for (int v = 0; v < 7; v++) begin
      applyStimulus(tbl[v].n0, tbl[v].d0, tbl[v].n1, tbl[v].d1);
      for (int c = 0; c < tbl[v].cyc; c++) cycle();
      checkVal($sformatf("v%0d_cfg_err", v), int'(cfg_err), int'(tbl[v].err));
      checkVal($sformatf("v%0d_ch0_pulses", v), pc[0], tbl[v].p0);
      checkVal($sformatf("v%0d_ch1_pulses", v), pc[1], tbl[v].p1);
      checkVal($sformatf("v%0d_ch0_p", v), pp[0], (tbl[v].p0 + 1) / 2);
      checkVal($sformatf("v%0d_ch0_n", v), pn[0], tbl[v].p0 / 2);
      checkVal($sformatf("v%0d_ch1_p", v), pp[1], (tbl[v].p1 + 1) / 2);
    end

    // pulse positions of 2/5 after load: edges 3, 5, 8, 10
    applyStimulus(2, 5, 2, 5);
    found = 0;
    for (int e = 1; e <= 12; e++) begin
      cycle();
      if (cen[0] && found < 4) begin
        first_pos[found] = e;
        found++;
      end
    end
    checkVal("pos_count", found, 4);
    checkVal("pos_1", first_pos[0], 3);
    checkVal("pos_2", first_pos[1], 5);
    checkVal("pos_3", first_pos[2], 8);
    checkVal("pos_4", first_pos[3], 10);

    // pause ch0 for 17 cycles mid-run
    applyStimulus(2, 5, 4, 25);
    for (int c = 0; c < 20; c++) cycle();
    pause = 2'b01;
    for (int c = 0; c < 17; c++) cycle();
    pause = 2'b00;
    for (int c = 0; c < 63; c++) cycle();
    checkVal("pause_ch0_pulses", pc[0], 33);
    checkVal("pause_ch1_pulses", pc[1], 16);

    // cfg_load coincident with pause: load wins, pulse ceil(3/1)=3 after release
    applyStimulus(1, 2, 1, 2);
    cycle();
    pause = 2'b01;
    applyStimulus(1, 3, 1, 3);
    for (int c = 0; c < 4; c++) cycle();
    checkVal("loadpause_ch0_silent", pc[0], 0);
    checkVal("loadpause_ch1_runs", pc[1], 1);
    pause = 2'b00;
    wait_cyc = 0;
    found = 0;
    while (!found && wait_cyc < 20) begin
      cycle();
      wait_cyc++;
      if (cen[0]) found = 1;
    end
    checkVal("loadpause_latency", wait_cyc, 3);

    // reset mid-stream after pulse 1 (ph=1, acc=1)
    applyStimulus(2, 5, 2, 5);
    for (int c = 0; c < 3; c++) cycle();
    checkVal("pre_reset_pulse", pc[0], 1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    checkVal("midreset_outputs", int'({cfg_err, cen_n, cen_p, cen}), 0);
    clearCounts();
    for (int c = 0; c < 20; c++) cycle();
    checkVal("post_reset_silent", pc[0] + pc[1], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
